// File: rtl/mb8_pipe_mac.sv
// Pipelined radix-8 Booth multiply/accumulate datapath fed with pre-encoded digits.
// Global-stall valid/ready flow control, 1..3 stage latency, running accumulation.
module mb8_pipe_mac #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned GROUPS    = (WIDTH + 3) / 3,
   parameter int unsigned STAGES    = 2,
   parameter int unsigned ACC_GUARD = 4,
   parameter int unsigned MY_SIGNED = 0,
   localparam int unsigned ACC_W    = 2 * WIDTH + ACC_GUARD
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_acc,
   input  logic [GROUPS-1:0] s,
   input  logic [GROUPS-1:0] d,
   input  logic [GROUPS-1:0] t,
   input  logic [GROUPS-1:0] q,
   input  logic [GROUPS-1:0] n,
   input  logic [WIDTH-1:0]  my,
   input  logic [WIDTH+1:0]  tmy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_product,
   output logic              out_err
);

   localparam int unsigned HALF   = (GROUPS + 1) / 2;
   localparam bit          MY_SGN = (MY_SIGNED != 0);

   logic              adv;
   logic              out_valid_q;
   logic [ACC_W-1:0]  out_product_q;
   logic [ACC_W-1:0]  out_product_d;
   logic              out_err_q;
   logic [ACC_W-1:0]  acc_q;

   // Stage-0 view of the beat (registered or straight from the ports)
   logic              v0, acc0;
   logic [GROUPS-1:0] s0, d0, t0, q0, n0;
   logic [WIDTH-1:0]  my0;
   logic [WIDTH+1:0]  tmy0;

   // Partial-product generation results
   logic [ACC_W-1:0]  sum_lo_c, sum_hi_c;
   logic              err_c;

   // Last-stage view
   logic              v1, acc1, err1;
   logic [ACC_W-1:0]  lo1, hi1;

   assign adv      = ~out_valid_q | out_ready;
   assign in_ready = adv;

   generate
      if (STAGES >= 2) begin : g_in_reg
         logic              v_q, acc_q0;
         logic [GROUPS-1:0] s_q, d_q, t_q, q_q, n_q;
         logic [WIDTH-1:0]  my_q;
         logic [WIDTH+1:0]  tmy_q;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               v_q    <= 1'b0;
               acc_q0 <= 1'b0;
               s_q    <= '0;
               d_q    <= '0;
               t_q    <= '0;
               q_q    <= '0;
               n_q    <= '0;
               my_q   <= '0;
               tmy_q  <= '0;
            end else if (adv) begin
               v_q    <= in_valid;
               acc_q0 <= in_acc;
               s_q    <= s;
               d_q    <= d;
               t_q    <= t;
               q_q    <= q;
               n_q    <= n;
               my_q   <= my;
               tmy_q  <= tmy;
            end
         end

         assign v0   = v_q;
         assign acc0 = acc_q0;
         assign s0   = s_q;
         assign d0   = d_q;
         assign t0   = t_q;
         assign q0   = q_q;
         assign n0   = n_q;
         assign my0  = my_q;
         assign tmy0 = tmy_q;
      end else begin : g_in_pass
         assign v0   = in_valid;
         assign acc0 = in_acc;
         assign s0   = s;
         assign d0   = d;
         assign t0   = t;
         assign q0   = q;
         assign n0   = n;
         assign my0  = my;
         assign tmy0 = tmy;
      end
   endgenerate

   // Per-group digit select, split into two partial sums for the optional mid register
   always_comb begin
      logic [ACC_W-1:0] my_x, tmy_x, mag, pp;
      logic             ill;
      my_x     = {{(ACC_W-WIDTH){MY_SGN & my0[WIDTH-1]}}, my0};
      tmy_x    = {{(ACC_W-WIDTH-2){MY_SGN & tmy0[WIDTH+1]}}, tmy0};
      mag      = '0;
      pp       = '0;
      ill      = 1'b0;
      sum_lo_c = '0;
      sum_hi_c = '0;
      err_c    = 1'b0;
      for (int g = 0; g < int'(GROUPS); g++) begin
         ill = (s0[g] & d0[g]) | (s0[g] & t0[g]) | (s0[g] & q0[g]) |
               (d0[g] & t0[g]) | (d0[g] & q0[g]) | (t0[g] & q0[g]);
         if (ill)        mag = '0;
         else if (s0[g]) mag = my_x;
         else if (d0[g]) mag = my_x << 1;
         else if (t0[g]) mag = tmy_x;
         else if (q0[g]) mag = my_x << 2;
         else            mag = '0;
         pp = n0[g] ? (ACC_W'(0) - mag) : mag;
         pp = pp << (3 * g);
         if (g < int'(HALF)) sum_lo_c = sum_lo_c + pp;
         else                sum_hi_c = sum_hi_c + pp;
         err_c = err_c | ill;
      end
   end

   generate
      if (STAGES >= 3) begin : g_mid_reg
         logic             v_q, acc_mq, err_q;
         logic [ACC_W-1:0] lo_q, hi_q;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               v_q    <= 1'b0;
               acc_mq <= 1'b0;
               err_q  <= 1'b0;
               lo_q   <= '0;
               hi_q   <= '0;
            end else if (adv) begin
               v_q    <= v0;
               acc_mq <= acc0;
               err_q  <= err_c;
               lo_q   <= sum_lo_c;
               hi_q   <= sum_hi_c;
            end
         end

         assign v1   = v_q;
         assign acc1 = acc_mq;
         assign err1 = err_q;
         assign lo1  = lo_q;
         assign hi1  = hi_q;
      end else begin : g_mid_pass
         assign v1   = v0;
         assign acc1 = acc0;
         assign err1 = err_c;
         assign lo1  = sum_lo_c;
         assign hi1  = sum_hi_c;
      end
   endgenerate

   // Output stage only loads on adv; a valid output then always handshakes this cycle,
   // so its value is forwarded as the accumulator the next beat must see.
   always_comb begin
      logic [ACC_W-1:0] acc_eff, p_c;
      acc_eff       = out_valid_q ? out_product_q : acc_q;
      p_c           = lo1 + hi1;
      out_product_d = acc1 ? (acc_eff + p_c) : p_c;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         out_valid_q   <= 1'b0;
         out_product_q <= '0;
         out_err_q     <= 1'b0;
         acc_q         <= '0;
      end else begin
         if (out_valid_q & out_ready) acc_q <= out_product_q;
         if (adv) begin
            out_valid_q <= v1;
            if (v1) begin
               out_product_q <= out_product_d;
               out_err_q     <= err1;
            end
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;
   assign out_err     = out_err_q;

endmodule

// File: tb/tb_mb8_pipe_mac.sv
// Directed bench for mb8_pipe_mac: WIDTH=8, STAGES=2, ACC_W=20, plus a MY_SIGNED=1 twin.
module tb_mb8_pipe_mac;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_acc = 1'b0;
   logic [2:0]  s = '0, d = '0, t = '0, q = '0, n = '0;
   logic [7:0]  my = '0;
   logic [9:0]  tmy = '0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, out_err;
   logic [19:0] out_product;
   logic        in_ready1, out_valid1, out_err1;
   logic [19:0] out_product1;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   mb8_pipe_mac u_dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
      .s(s), .d(d), .t(t), .q(q), .n(n), .my(my), .tmy(tmy),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .out_err(out_err)
   );

   mb8_pipe_mac #(.MY_SIGNED(1)) u_dut_s (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1), .in_acc(in_acc),
      .s(s), .d(d), .t(t), .q(q), .n(n), .my(my), .tmy(tmy),
      .out_valid(out_valid1), .out_ready(out_ready), .out_product(out_product1), .out_err(out_err1)
   );

   task automatic set_beat(input logic a, input logic [2:0] vs, vd, vt, vq, vn,
                           input logic [7:0] m, input logic [9:0] tm);
      in_acc = a; s = vs; d = vd; t = vt; q = vq; n = vn; my = m; tmy = tm;
   endtask

   // Push one beat into an empty pipe and capture its result; lat counts edges to out_valid.
   task automatic run_beat(input logic a, input logic [2:0] vs, vd, vt, vq, vn,
                           input logic [7:0] m, input logic [9:0] tm,
                           output logic [19:0] p0, output logic e0,
                           output logic [19:0] p1, output int lat);
      set_beat(a, vs, vd, vt, vq, vn, m, tm);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge CLK); #1;
         lat++;
      end
      p0 = out_product;
      e0 = out_err;
      p1 = out_product1;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_product !== 20'h0) begin bad++; $display("FAIL reset_product got=%h exp=00000", out_product); end
      total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", out_err); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_basic();
      logic [19:0] p0, p1; logic e0; int lat;
      run_beat(1'b0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 8'd5, 10'd15, p0, e0, p1, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL latency got=%0d exp=2", lat); end
      total++; if (p0 !== 20'h00023) begin bad++; $display("FAIL basic35 got=%h exp=00023", p0); end
      total++; if (e0 !== 1'b0) begin bad++; $display("FAIL basic35_err got=%b exp=0", e0); end
      run_beat(1'b0, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 8'd255, 10'd765, p0, e0, p1, lat);
      total++; if (p0 !== 20'h01BE4) begin bad++; $display("FAIL basic7140 got=%h exp=01BE4", p0); end
      run_beat(1'b0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 8'd5, 10'd15, p0, e0, p1, lat);
      total++; if (p0 !== 20'h00028) begin bad++; $display("FAIL neg_zero got=%h exp=00028", p0); end
      total++; if (e0 !== 1'b0) begin bad++; $display("FAIL neg_zero_err got=%b exp=0", e0); end
      run_beat(1'b0, 3'b000, 3'b100, 3'b000, 3'b010, 3'b100, 8'd7, 10'd21, p0, e0, p1, lat);
      total++; if (p0 !== 20'hFFD60) begin bad++; $display("FAIL group2 got=%h exp=FFD60", p0); end
   endtask

   task automatic test_back_to_back();
      set_beat(1'b0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 8'd5, 10'd15);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      set_beat(1'b1, 3'b011, 3'b000, 3'b000, 3'b000, 3'b001, 8'd5, 10'd15);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_product !== 20'h00023) begin
         bad++; $display("FAIL b2b_first got=%b/%h exp=1/00023", out_valid, out_product); end
      @(posedge CLK); #1;
      total++; if (out_valid !== 1'b1 || out_product !== 20'h00046) begin
         bad++; $display("FAIL b2b_second got=%b/%h exp=1/00046", out_valid, out_product); end
      @(posedge CLK); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_negative();
      logic [19:0] p0, p1; logic e0; int lat;
      run_beat(1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 8'd3, 10'd9, p0, e0, p1, lat);
      total++; if (p0 !== 20'hFFFF4) begin bad++; $display("FAIL neg4 got=%h exp=FFFF4", p0); end
      run_beat(1'b1, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 8'd3, 10'd9, p0, e0, p1, lat);
      total++; if (p0 !== 20'h00000) begin bad++; $display("FAIL acc_wrap got=%h exp=00000", p0); end
      run_beat(1'b0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 8'hFF, 10'h3FD, p0, e0, p1, lat);
      total++; if (p1 !== 20'hFFFFC) begin bad++; $display("FAIL signed_my got=%h exp=FFFFC", p1); end
      total++; if (p0 !== 20'h003FC) begin bad++; $display("FAIL unsigned_my got=%h exp=003FC", p0); end
   endtask

   task automatic test_illegal();
      logic [19:0] p0, p1; logic e0; int lat;
      run_beat(1'b0, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000, 8'd5, 10'd15, p0, e0, p1, lat);
      total++; if (p0 !== 20'h00028) begin bad++; $display("FAIL illegal_prod got=%h exp=00028", p0); end
      total++; if (e0 !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", e0); end
      run_beat(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 8'd5, 10'd15, p0, e0, p1, lat);
      total++; if (p0 !== 20'h00005 || e0 !== 1'b0) begin
         bad++; $display("FAIL legal_after got=%h/%b exp=00005/0", p0, e0); end
   endtask

   task automatic test_stall();
      int sent = 0, got = 0;
      logic [19:0] held = '0;
      logic held_v = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         out_ready = !(cyc >= 3 && cyc < 6);
         in_valid  = (sent < 4);
         set_beat(1'b0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 8'(sent + 1), 10'(3 * (sent + 1)));
         @(negedge CLK);
         if (out_valid && !out_ready) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
            if (held_v) begin
               total++; if (out_product !== held) begin
                  bad++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, out_product, held); end
            end
            held = out_product; held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            total++; if (out_product !== 20'(got + 1)) begin
               bad++; $display("FAIL stream_data idx=%0d got=%h exp=%h", got, out_product, 20'(got + 1)); end
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge CLK); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++; if (got !== 4 || sent !== 4) begin bad++; $display("FAIL stream_count got=%0d/%0d exp=4/4", got, sent); end
   endtask

   task automatic test_reset_flight();
      logic [19:0] p0, p1; logic e0; int lat;
      int seen = 0;
      set_beat(1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 8'd9, 10'd27);
      in_valid = 1'b1;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      RST = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || out_valid1 !== 1'b0) begin
         bad++; $display("FAIL rst_flush got=%b/%b exp=0/0", out_valid, out_valid1); end
      @(posedge CLK); #1;
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid !== 1'b0) seen++;
         @(posedge CLK); #1;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rst_ghost got=%0d exp=0", seen); end
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready1); end
      run_beat(1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 8'd5, 10'd15, p0, e0, p1, lat);
      total++; if (p0 !== 20'h00005) begin bad++; $display("FAIL rst_acc got=%h exp=00005", p0); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_negative();
      test_illegal();
      test_stall();
      test_reset_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
